branch_resolution_unit: RTL and testbench
=========================================

# branch_resolution_unit

Execute-stage block that resolves conditional branches and JAL instructions, detects mispredictions against the fetch-stage prediction, and produces the update, invalidate and redirect traffic consumed by the branch predictor and fetch. It is the writer side of the predictor interface. It registers one resolved instruction per accepted handshake. It holds the pipeline while a fetch redirect is outstanding.

## Interface
- ADDR_W, 32, instruction address width
- CNT_W, 16, misprediction counter width
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset. **Asynchronous, active-low.**
- s_exe_valid_i  in  1  resolved instruction presented
- s_exe_ready_o  out  1  unit can accept an instruction
- s_exe_branch_i  in  1  instruction is a conditional branch
- s_exe_jal_i  in  1  instruction is JAL
- s_exe_taken_i  in  1  branch condition true (ignored for JAL, treated as 1)
- s_exe_rvc_i  in  1  instruction is compressed
- s_exe_pc_i  in  32  instruction address
- s_exe_imm_i  in  21  sign-extended immediate, bit 0 is zero
- s_exe_pred_i  in  1  fetch predicted taken
- s_exe_ptarget_i  in  32  fetch-predicted target
- s_branch_update_o  out  1  predictor update strobe
- s_branch_taken_o  out  1  resolved direction
- s_ualigc_o  out  1  unaligned RVC (rvc & pc[1])
- s_btb_update_o  out  1  write BTB entry
- s_branch_offset_o  out  12  imm[12:1]
- s_branch_add_o  out  32  instruction address
- s_invalidate_o  out  1  invalidate predictor entry at s_branch_add_o
- s_redirect_o  out  1  fetch redirect request
- s_redirect_ready_i  in  1  fetch accepts redirect
- s_redirect_add_o  out  32  correct next address
- s_mispred_cnt_o  out  CNT_W  wrapping misprediction count

## Operation
- Accept on s_exe_valid_i & s_exe_ready_o. Compute the following from the accepted inputs:
  - **target** = pc + imm.
  - **seq** = pc + (rvc ? 2 : 4).
  - **taken** = jal | (branch & s_exe_taken_i).
  - **next** = taken ? target : seq.
- **fits**: imm[20:12] all equal (13-bit signed range).
- **Branch/JAL accepted**:
  - branch_update = 1 and branch_taken = taken.
  - btb_update = taken & fits.
  - offset = imm[12:1].
  - ualigc = rvc & pc[1].
- **Non-branch accepted with pred = 1**: invalidate = 1 and branch_update = 0.
- **Mispredict**: pred != taken, or (pred & taken & ptarget != target), or non-branch with pred.
  - On mispredict, the redirect address is next (seq for a non-branch).
  - s_mispred_cnt_o increments by 1 and wraps at 2^CNT_W.
- **FSM**:
  - **IDLE**: ready = 1. Accept with mispredict → REDIR. Accept without mispredict → IDLE.
  - **REDIR**: ready = 0, s_redirect_o = 1, s_redirect_add_o stable. Transition to IDLE on s_redirect_ready_i.
- Update and invalidate outputs are one-cycle pulses. Address, offset, taken and ualigc hold their values until the next accept.
- The valid bit is never set for an instruction that is not JAL or a branch.

## Timing
- Reset value of every output is 0, with two exceptions: s_exe_ready_o = 1 and the FSM is in IDLE.
- Accept in cycle N → update, invalidate and redirect visible in cycle N+1 (registered outputs). No combinational path from s_exe_* to outputs.
- A redirect can complete no earlier than N+1, when s_redirect_ready_i is already high; the unit is ready again at N+2.
- s_redirect_o stays high until ready. s_redirect_add_o is unchanged while waiting.
- s_exe_ready_o falls in N+1 for a mispredict, so a back-to-back accept in N+1 is impossible.
- Reset asserted in REDIR: the redirect is dropped immediately, the counter is cleared and the FSM returns to IDLE.
- Counter wrap: all ones + 1 → 0 with no saturation.

## Structure
- p_hardisc gains the following; the sequential register count is small, so no seu_ff file is needed:
  - typedef enum bru_state_t {BRU_IDLE, BRU_REDIR}
  - BP_OFFSET_W = 12
  - the RVC/RVI step constants (2, 4)
- Reuse fast_adder (ADDONLY=0) for the target computation. fast_adder is the only sub-module. The seq addition and the comparator are plain logic.
- The output register bank uses seu_ff_rst with LABEL "BRU" and GROUP SEEGR_PREDICTOR.

## Test plan
- Branch at pc=0x100, imm=+0x40, taken, pred=1, ptarget=0x140 → N+1:
  - update=1, taken=1, btb=1, offset=0x020, add=0x100
  - no redirect, count unchanged
- Same branch not taken, pred=1 → redirect=1, add=0x104, count=1, ready=0. With s_redirect_ready_i held low for 3 cycles, the redirect holds; ready returns after acceptance.
- RVC JAL at pc=0x202, imm=-4, pred=0 → ualigc=1, btb=1, offset=0xFFE, redirect add=0x1FE.
- JAL imm=+0x2000 (does not fit), pred=0 → update=1, btb=0, redirect add=pc+0x2000.
- Non-branch at 0x300 with pred=1 → invalidate=1, update=0, redirect add=0x304 (0x302 for RVC).
- Reset pulsed while in REDIR → all outputs 0, ready=1. Counter preset to 0xFFFF then one mispredict → 0x0000.

Source files
------------

// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_resolution_unit_pkg;

   typedef enum logic [0:0] {
      BRU_IDLE  = 1'b0,
      BRU_REDIR = 1'b1
   } bru_state_t;

   localparam int BP_OFFSET_W = 12;
   localparam int IMM_W       = 21;
   localparam int RVC_STEP    = 2;
   localparam int RVI_STEP    = 4;

   // An immediate fits the BTB offset field when bits 20..12 are pure sign extension.
   function automatic logic imm_fits(input logic [IMM_W-1:0] imm);
      return (&imm[IMM_W-1:BP_OFFSET_W]) | ~(|imm[IMM_W-1:BP_OFFSET_W]);
   endfunction

endpackage

// File: rtl/branch_resolution_unit_fast_adder.sv
// Generic adder; with ADDONLY=0 it also subtracts when sub_i is set.
module fast_adder #(
   parameter int W       = 32,
   parameter bit ADDONLY = 1'b0
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] sum_o
);

   generate
      if (ADDONLY) begin : g_add
         logic unused_sub;
         assign unused_sub = sub_i;
         // Plain addition
         always_comb sum_o = a_i + b_i;
      end else begin : g_addsub
         // Two's complement subtract by inverting b and injecting carry
         always_comb sum_o = a_i + (sub_i ? ~b_i : b_i) + {{(W-1){1'b0}}, sub_i};
      end
   endgenerate

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves branches/JAL in execute, flags mispredictions, drives predictor
// update/invalidate and the fetch redirect handshake.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   BRU_IDLE  | ready for the next resolved instruction
//   BRU_REDIR | redirect pending; pipeline held until fetch accepts it
module branch_resolution_unit
   import branch_resolution_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                   s_clk_i,
   input  logic                   s_resetn_i,
   input  logic                   s_exe_valid_i,
   output logic                   s_exe_ready_o,
   input  logic                   s_exe_branch_i,
   input  logic                   s_exe_jal_i,
   input  logic                   s_exe_taken_i,
   input  logic                   s_exe_rvc_i,
   input  logic [ADDR_W-1:0]      s_exe_pc_i,
   input  logic [IMM_W-1:0]       s_exe_imm_i,
   input  logic                   s_exe_pred_i,
   input  logic [ADDR_W-1:0]      s_exe_ptarget_i,
   output logic                   s_branch_update_o,
   output logic                   s_branch_taken_o,
   output logic                   s_ualigc_o,
   output logic                   s_btb_update_o,
   output logic [BP_OFFSET_W-1:0] s_branch_offset_o,
   output logic [ADDR_W-1:0]      s_branch_add_o,
   output logic                   s_invalidate_o,
   output logic                   s_redirect_o,
   input  logic                   s_redirect_ready_i,
   output logic [ADDR_W-1:0]      s_redirect_add_o,
   output logic [CNT_W-1:0]       s_mispred_cnt_o
);

   bru_state_t             state_q, state_d;
   logic                   update_q, update_d;
   logic                   taken_q, taken_d;
   logic                   ualigc_q, ualigc_d;
   logic                   btb_q, btb_d;
   logic [BP_OFFSET_W-1:0] offset_q, offset_d;
   logic [ADDR_W-1:0]      add_q, add_d;
   logic                   inval_q, inval_d;
   logic [ADDR_W-1:0]      redir_add_q, redir_add_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [ADDR_W-1:0] imm_ext;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] seq;
   logic [ADDR_W-1:0] next_pc;
   logic              is_cf;
   logic              res_taken;
   logic              mispred;
   logic              accept;
   logic              unused_imm0;

   assign unused_imm0 = s_exe_imm_i[0];
   assign imm_ext     = {{(ADDR_W-IMM_W){s_exe_imm_i[IMM_W-1]}}, s_exe_imm_i};

   fast_adder #(
      .W       (ADDR_W),
      .ADDONLY (1'b0)
   ) u_target_add (
      .a_i   (s_exe_pc_i),
      .b_i   (imm_ext),
      .sub_i (1'b0),
      .sum_o (target)
   );

   // Resolution: direction, fall-through address and misprediction detect
   always_comb begin
      is_cf     = s_exe_branch_i | s_exe_jal_i;
      res_taken = s_exe_jal_i | (s_exe_branch_i & s_exe_taken_i);
      seq       = s_exe_pc_i + (s_exe_rvc_i ? ADDR_W'(RVC_STEP) : ADDR_W'(RVI_STEP));
      next_pc   = res_taken ? target : seq;
      // A non-branch predicted taken shows up here as pred != taken (taken is 0)
      mispred   = (s_exe_pred_i != res_taken)
                | (s_exe_pred_i & res_taken & (s_exe_ptarget_i != target));
      accept    = s_exe_valid_i & (state_q == BRU_IDLE);
   end

   // Next-state for the FSM and the output register bank
   always_comb begin
      state_d     = state_q;
      update_d    = 1'b0;
      btb_d       = 1'b0;
      inval_d     = 1'b0;
      taken_d     = taken_q;
      ualigc_d    = ualigc_q;
      offset_d    = offset_q;
      add_d       = add_q;
      redir_add_d = redir_add_q;
      cnt_d       = cnt_q;
      case (state_q)
         BRU_IDLE: begin
            if (accept) begin
               update_d = is_cf;
               btb_d    = is_cf & res_taken & imm_fits(s_exe_imm_i);
               inval_d  = ~is_cf & s_exe_pred_i;
               taken_d  = res_taken;
               ualigc_d = s_exe_rvc_i & s_exe_pc_i[1];
               offset_d = s_exe_imm_i[BP_OFFSET_W:1];
               add_d    = s_exe_pc_i;
               if (mispred) begin
                  redir_add_d = next_pc;
                  cnt_d       = cnt_q + CNT_W'(1);
                  state_d     = BRU_REDIR;
               end
            end
         end
         BRU_REDIR: begin
            if (s_redirect_ready_i) begin
               state_d = BRU_IDLE;
            end
         end
         default: state_d = BRU_IDLE;
      endcase
   end

   // State and output registers; reset drops any pending redirect at once
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q     <= BRU_IDLE;
         update_q    <= 1'b0;
         taken_q     <= 1'b0;
         ualigc_q    <= 1'b0;
         btb_q       <= 1'b0;
         offset_q    <= '0;
         add_q       <= '0;
         inval_q     <= 1'b0;
         redir_add_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         update_q    <= update_d;
         taken_q     <= taken_d;
         ualigc_q    <= ualigc_d;
         btb_q       <= btb_d;
         offset_q    <= offset_d;
         add_q       <= add_d;
         inval_q     <= inval_d;
         redir_add_q <= redir_add_d;
         cnt_q       <= cnt_d;
      end
   end

   assign s_exe_ready_o     = (state_q == BRU_IDLE);
   assign s_redirect_o      = (state_q == BRU_REDIR);
   assign s_branch_update_o = update_q;
   assign s_branch_taken_o  = taken_q;
   assign s_ualigc_o        = ualigc_q;
   assign s_btb_update_o    = btb_q;
   assign s_branch_offset_o = offset_q;
   assign s_branch_add_o    = add_q;
   assign s_invalidate_o    = inval_q;
   assign s_redirect_add_o  = redir_add_q;
   assign s_mispred_cnt_o   = cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit; a narrow-counter twin checks wrap.
module tb_branch_resolution_unit;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        branch;
   logic        jal;
   logic        tkn;
   logic        rvc;
   logic [31:0] pc;
   logic [20:0] imm;
   logic        pred;
   logic [31:0] ptarget;
   logic        redir_rdy;

   logic        ready, update, taken_o, ualigc, btb, inval, redir;
   logic [11:0] offset;
   logic [31:0] add, redir_add;
   logic [15:0] cnt;

   logic        w_ready, w_update, w_taken, w_ualigc, w_btb, w_inval, w_redir;
   logic [11:0] w_offset;
   logic [31:0] w_add, w_redir_add;
   logic [3:0]  w_cnt;

   int n_cmp;
   int n_err;
   int exp_cnt;

   branch_resolution_unit #(.ADDR_W(32), .CNT_W(16)) u_dut (
      .s_clk_i            (clk),
      .s_resetn_i         (rst_n),
      .s_exe_valid_i      (valid),
      .s_exe_ready_o      (ready),
      .s_exe_branch_i     (branch),
      .s_exe_jal_i        (jal),
      .s_exe_taken_i      (tkn),
      .s_exe_rvc_i        (rvc),
      .s_exe_pc_i         (pc),
      .s_exe_imm_i        (imm),
      .s_exe_pred_i       (pred),
      .s_exe_ptarget_i    (ptarget),
      .s_branch_update_o  (update),
      .s_branch_taken_o   (taken_o),
      .s_ualigc_o         (ualigc),
      .s_btb_update_o     (btb),
      .s_branch_offset_o  (offset),
      .s_branch_add_o     (add),
      .s_invalidate_o     (inval),
      .s_redirect_o       (redir),
      .s_redirect_ready_i (redir_rdy),
      .s_redirect_add_o   (redir_add),
      .s_mispred_cnt_o    (cnt)
   );

   branch_resolution_unit #(.ADDR_W(32), .CNT_W(4)) u_dut_w (
      .s_clk_i            (clk),
      .s_resetn_i         (rst_n),
      .s_exe_valid_i      (valid),
      .s_exe_ready_o      (w_ready),
      .s_exe_branch_i     (branch),
      .s_exe_jal_i        (jal),
      .s_exe_taken_i      (tkn),
      .s_exe_rvc_i        (rvc),
      .s_exe_pc_i         (pc),
      .s_exe_imm_i        (imm),
      .s_exe_pred_i       (pred),
      .s_exe_ptarget_i    (ptarget),
      .s_branch_update_o  (w_update),
      .s_branch_taken_o   (w_taken),
      .s_ualigc_o         (w_ualigc),
      .s_btb_update_o     (w_btb),
      .s_branch_offset_o  (w_offset),
      .s_branch_add_o     (w_add),
      .s_invalidate_o     (w_inval),
      .s_redirect_o       (w_redir),
      .s_redirect_ready_i (redir_rdy),
      .s_redirect_add_o   (w_redir_add),
      .s_mispred_cnt_o    (w_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction at the negedge; returns #1 after the accepting edge
   task automatic present(input logic b, input logic j, input logic t, input logic c,
                          input logic [31:0] p, input logic [20:0] i,
                          input logic pr, input logic [31:0] pt);
      @(negedge clk);
      check_eq("ready_before_accept", 64'(ready), 64'(1));
      valid   = 1'b1;
      branch  = b;
      jal     = j;
      tkn     = t;
      rvc     = c;
      pc      = p;
      imm     = i;
      pred    = pr;
      ptarget = pt;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // Grant the pending redirect and confirm the unit returns to idle
   task automatic finish_redirect();
      @(negedge clk);
      redir_rdy = 1'b1;
      @(posedge clk);
      #1;
      check_eq("redir_dropped", 64'(redir), 64'(0));
      check_eq("ready_back", 64'(ready), 64'(1));
      redir_rdy = 1'b0;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      exp_cnt   = 0;
      rst_n     = 1'b0;
      valid     = 1'b0;
      branch    = 1'b0;
      jal       = 1'b0;
      tkn       = 1'b0;
      rvc       = 1'b0;
      pc        = '0;
      imm       = '0;
      pred      = 1'b0;
      ptarget   = '0;
      redir_rdy = 1'b0;

      #3;
      check_eq("rst_ready", 64'(ready), 64'(1));
      check_eq("rst_redir", 64'(redir), 64'(0));
      check_eq("rst_update", 64'(update), 64'(0));
      check_eq("rst_add", 64'(add), 64'(0));
      check_eq("rst_cnt", 64'(cnt), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Correctly predicted taken branch
      present(1, 0, 1, 0, 32'h100, 21'h40, 1, 32'h140);
      check_eq("t1_update", 64'(update), 64'(1));
      check_eq("t1_taken", 64'(taken_o), 64'(1));
      check_eq("t1_btb", 64'(btb), 64'(1));
      check_eq("t1_offset", 64'(offset), 64'h020);
      check_eq("t1_add", 64'(add), 64'h100);
      check_eq("t1_redir", 64'(redir), 64'(0));
      check_eq("t1_cnt", 64'(cnt), 64'(0));
      check_eq("t1_ready", 64'(ready), 64'(1));
      @(posedge clk);
      #1;
      check_eq("t1_update_pulse", 64'(update), 64'(0));
      check_eq("t1_add_hold", 64'(add), 64'h100);

      // Same branch not taken, predicted taken: redirect to fall-through
      present(1, 0, 0, 0, 32'h100, 21'h40, 1, 32'h140);
      exp_cnt++;
      check_eq("t2_redir", 64'(redir), 64'(1));
      check_eq("t2_redir_add", 64'(redir_add), 64'h104);
      check_eq("t2_cnt", 64'(cnt), 64'(exp_cnt));
      check_eq("t2_ready", 64'(ready), 64'(0));
      check_eq("t2_taken", 64'(taken_o), 64'(0));
      check_eq("t2_btb", 64'(btb), 64'(0));
      valid = 1'b1;
      branch = 1'b1;
      pc = 32'h900;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_eq("t2_hold_redir", 64'(redir), 64'(1));
         check_eq("t2_hold_add", 64'(redir_add), 64'h104);
         check_eq("t2_hold_ready", 64'(ready), 64'(0));
         check_eq("t2_no_accept", 64'(add), 64'h100);
      end
      valid = 1'b0;
      finish_redirect();

      // RVC JAL, unaligned, backwards; redirect granted immediately
      redir_rdy = 1'b1;
      present(0, 1, 0, 1, 32'h202, 21'h1FFFFC, 0, 32'h0);
      exp_cnt++;
      check_eq("t3_ualigc", 64'(ualigc), 64'(1));
      check_eq("t3_btb", 64'(btb), 64'(1));
      check_eq("t3_offset", 64'(offset), 64'hFFE);
      check_eq("t3_redir", 64'(redir), 64'(1));
      check_eq("t3_redir_add", 64'(redir_add), 64'h1FE);
      check_eq("t3_cnt", 64'(cnt), 64'(exp_cnt));
      @(posedge clk);
      #1;
      check_eq("t3_redir_done", 64'(redir), 64'(0));
      check_eq("t3_ready", 64'(ready), 64'(1));
      redir_rdy = 1'b0;

      // JAL whose offset does not fit the BTB field
      present(0, 1, 0, 0, 32'h400, 21'h2000, 0, 32'h0);
      exp_cnt++;
      check_eq("t4_update", 64'(update), 64'(1));
      check_eq("t4_btb", 64'(btb), 64'(0));
      check_eq("t4_offset", 64'(offset), 64'h000);
      check_eq("t4_redir_add", 64'(redir_add), 64'h2400);
      finish_redirect();

      // Non-branch predicted taken: invalidate and redirect to next sequential
      present(0, 0, 1, 0, 32'h300, 21'h0, 1, 32'h500);
      exp_cnt++;
      check_eq("t5_inval", 64'(inval), 64'(1));
      check_eq("t5_update", 64'(update), 64'(0));
      check_eq("t5_btb", 64'(btb), 64'(0));
      check_eq("t5_add", 64'(add), 64'h300);
      check_eq("t5_redir_add", 64'(redir_add), 64'h304);
      @(posedge clk);
      #1;
      check_eq("t5_inval_pulse", 64'(inval), 64'(0));
      finish_redirect();
      present(0, 0, 0, 1, 32'h300, 21'h0, 1, 32'h0);
      exp_cnt++;
      check_eq("t5c_redir_add", 64'(redir_add), 64'h302);
      check_eq("t5c_cnt", 64'(cnt), 64'(exp_cnt));
      finish_redirect();

      // Non-branch not predicted: nothing happens
      present(0, 0, 0, 0, 32'h310, 21'h0, 0, 32'h0);
      check_eq("t6_inval", 64'(inval), 64'(0));
      check_eq("t6_update", 64'(update), 64'(0));
      check_eq("t6_redir", 64'(redir), 64'(0));
      check_eq("t6_cnt", 64'(cnt), 64'(exp_cnt));

      // Taken branch, right direction, wrong predicted target
      present(1, 0, 1, 0, 32'h500, 21'h10, 1, 32'h600);
      exp_cnt++;
      check_eq("t7_redir", 64'(redir), 64'(1));
      check_eq("t7_redir_add", 64'(redir_add), 64'h510);
      check_eq("t7_cnt", 64'(cnt), 64'(exp_cnt));
      check_eq("t7_wcnt", 64'(w_cnt), 64'(exp_cnt % 16));

      // Reset while a redirect is pending
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("t8_redir", 64'(redir), 64'(0));
      check_eq("t8_ready", 64'(ready), 64'(1));
      check_eq("t8_cnt", 64'(cnt), 64'(0));
      check_eq("t8_add", 64'(add), 64'(0));
      check_eq("t8_redir_add", 64'(redir_add), 64'(0));
      check_eq("t8_offset", 64'(offset), 64'(0));
      check_eq("t8_taken", 64'(taken_o), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;

      // Counter wrap on the 4-bit twin
      redir_rdy = 1'b1;
      for (int k = 0; k < 15; k++) begin
         present(1, 0, 0, 0, 32'h100, 21'h40, 1, 32'h140);
         exp_cnt++;
         @(posedge clk);
         #1;
      end
      check_eq("t9_wcnt_full", 64'(w_cnt), 64'hF);
      present(1, 0, 0, 0, 32'h100, 21'h40, 1, 32'h140);
      exp_cnt++;
      check_eq("t9_wcnt_wrap", 64'(w_cnt), 64'h0);
      check_eq("t9_cnt", 64'(cnt), 64'(exp_cnt));
      @(posedge clk);
      #1;
      redir_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
